// File: rtl/sequential_divider.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH iterations per operation.
// Optional macro DIV_ZERO_FAST_EN completes a divide-by-zero immediately instead of iterating.
module sequential_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   rem, quo, dvs;
    logic               accept, last_iter, fast_zero;
    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     diff;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (count == CW'(WIDTH - 1));
    assign shifted   = {rem, quo} << 1;
    assign diff      = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, dvs};

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (divisor == '0);
`else
    assign fast_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = fast_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = fast_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A negative trial difference means the divisor did not fit, so the shifted remainder is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count       <= '0;
            dvs         <= divisor;
            div_by_zero <= (divisor == '0);
            if (fast_zero) begin
                rem <= dividend;
                quo <= '1;
            end else begin
                rem <= '0;
                quo <= dividend;
            end
        end else if (state == RUN) begin
            count <= count + CW'(1);
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                quo <= {shifted[WIDTH-1:1], 1'b1};
            end else begin
                rem <= shifted[2*WIDTH-1:WIDTH];
                quo <= shifted[WIDTH-1:0];
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed cases plus random operands
// checked against a plain-arithmetic division model.
module tb_sequential_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;

    sequential_divider #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else begin
            failed_checks++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: ordinary integer division; divide-by-zero yields all ones and the dividend.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output int lat);
        lat = 17;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
`ifdef DIV_ZERO_FAST_EN
            lat = 1;
`endif
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at a falling edge; returns at the falling edge just after the accept edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic wait_done(input string tag, input int already, output int lat, output int busy_n);
        lat    = already;
        busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] exp_q, exp_r;
        int          exp_lat, lat, busy_n;
        model(a, b, exp_q, exp_r, exp_lat);
        applyStimulus(a, b);
        wait_done(tag, 1, lat, busy_n);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        checkOutput({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        checkOutput({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
        checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(b == 16'd0));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, busy_n;
        logic [15:0] ra, rb;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed operations");
        run_and_check("d1000_7", 16'd1000, 16'd7);
        run_and_check("dffff_1", 16'hFFFF, 16'd1);
        run_and_check("d3_10", 16'd3, 16'd10);
        run_and_check("d5_0", 16'd5, 16'd0);
        run_and_check("d0_0", 16'd0, 16'd0);
        run_and_check("dffff_ffff", 16'hFFFF, 16'hFFFF);
        run_and_check("dfffe_ffff", 16'hFFFE, 16'hFFFF);

        $display("[TB] start ignored while running");
        applyStimulus(16'd100, 16'd9);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored", 5, lat, busy_n);
        checkOutput("ignored_latency", 32'(lat), 32'd17);
        checkOutput("ignored_quotient", 32'(quotient), 32'd11);
        checkOutput("ignored_remainder", 32'(remainder), 32'd1);

        $display("[TB] back-to-back start in done cycle");
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_done_fell", 32'(done), 32'd0);
        checkOutput("b2b_busy_rose", 32'(busy), 32'd1);
        wait_done("b2b", 1, lat, busy_n);
        checkOutput("b2b_latency", 32'(lat), 32'd17);
        checkOutput("b2b_quotient", 32'(quotient), 32'd10);
        checkOutput("b2b_remainder", 32'(remainder), 32'd0);
        @(negedge clk);

        $display("[TB] reset mid-run");
        applyStimulus(16'd1000, 16'd7);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_quotient", 32'(quotient), 32'd0);
        checkOutput("midreset_remainder", 32'(remainder), 32'd0);
        start    = 1'b1;
        dividend = 16'd6;
        divisor  = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("start_with_reset_busy", 32'(busy), 32'd0);
        checkOutput("start_with_reset_done", 32'(done), 32'd0);
        checkOutput("start_with_reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        checkOutput("start_with_reset_idle", 32'(busy | done), 32'd0);
        run_and_check("d40000_300", 16'd40000, 16'd300);

        $display("[TB] random operations");
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            run_and_check($sformatf("rand%0d", i), ra, rb);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Iterative restoring divider for the NEANDER-X 16-bit datapath. It sits directly upstream of the ALU and supplies its quotient, remainder and divide-by-zero inputs for the DIV and MOD opcodes. It resolves one quotient bit per clock, trading 16 cycles of latency for a small area footprint. The control unit pulses `start`, stalls while `busy` is high, and lets the ALU consume results once `done` is seen.

## Interface
Parameters:
- `WIDTH`, 16, operand and result width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new division; sampled only when idle or in DONE.
- `dividend`  in  WIDTH  numerator (unsigned); latched when `start` is accepted.
- `divisor`  in  WIDTH  denominator (unsigned); latched when `start` is accepted.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse marking that results are valid.
- `quotient`  out  WIDTH  feeds ALU `div_quotient`.
- `remainder`  out  WIDTH  feeds ALU `div_remainder`.
- `div_by_zero`  out  1  feeds ALU `div_by_zero`; set when the latched divisor is 0.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iterating; a 5-bit counter runs 0..WIDTH-1.
  - DONE: `done`=1 for one cycle, then IDLE unless a new `start` is accepted.
- Accept: `start`=1 in IDLE or DONE. Actions on accept:
  - load rem=0, quo=`dividend`, dvs=`divisor`, count=0.
  - set `div_by_zero` = (`divisor`==0).
  - go to RUN.
- RUN iteration:
  - form {rem,quo} shifted left by 1.
  - compute diff = {1'b0, shifted rem} − {1'b0, dvs}, WIDTH+1 bits wide.
  - if diff[WIDTH]==0: rem=diff[WIDTH-1:0] and quo LSB=1; else keep the shifted rem and quo LSB=0.
  - on count==WIDTH-1, go to DONE.
- `quotient`/`remainder` expose the quo/rem registers. They are valid from DONE onward and held until the next accepted start. Mid-operation values are don't-care to consumers.
- Divisor 0 falls out of the algorithm naturally: quotient=all ones (16'hFFFF), remainder=dividend.
- `start` while in RUN is ignored; no queuing.
- Operand inputs may change freely after accept.
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, state IDLE, count=0.

## Timing
- `start` accepted at edge E0. Iterations occur at edges E1..E16. `done`=1 in the cycle after E16, and results are valid in that same cycle. Total latency is 17 cycles from the accept edge to `done`.
- `busy`=1 from after E0 through E16. It drops in the DONE cycle.
- Back-to-back: `start` in the DONE cycle is accepted at that edge. `done` falls and `busy` rises in the next cycle, with no idle gap.
- Reset asserted in any state, including mid-RUN: at the next edge all outputs take their reset values and any in-flight operation is discarded.
- `start` coincident with `reset`: ignored; reset wins.

## Configuration
- Macro `DIV_ZERO_FAST_EN`, for a faster divide-by-zero path.
- Defined: an accepted `start` with `divisor`==0 goes straight to DONE at E0.
  - loads `quotient`=16'hFFFF, `remainder`=`dividend`, `div_by_zero`=1.
  - `done`=1 in the cycle after E0; `busy` never asserts.
- Undefined: divisor 0 runs the full 16 iterations. Results and `div_by_zero` are identical; only the latency differs (17 cycles).
- Nonzero divisors behave identically in both builds.

## Test plan
- 1000 / 7: `done` exactly 17 cycles after accept, `quotient`=142, `remainder`=6, `div_by_zero`=0; `busy` high for 16 cycles.
- 16'hFFFF / 1, then 3 / 10: first gives q=16'hFFFF, r=0; second gives q=0, r=3.
- 5 / 0: q=16'hFFFF, r=5, `div_by_zero`=1. `done` comes 1 cycle after accept with `DIV_ZERO_FAST_EN` defined, 17 cycles without it.
- 100 / 9 started; `start` re-pulsed with 50 / 5 at iteration 4: second start ignored, result q=11, r=1.
  - Then assert `start` with 50 / 5 in the DONE cycle: accepted; after 17 more cycles q=10, r=0.
- `reset` asserted at iteration 8 of 1000 / 7: next cycle `busy`=0, `done`=0, `quotient`=0, `remainder`=0.
  - A following 40000 / 300 yields q=133, r=100.
